bin_window_3x3: RTL and testbench
=================================

Name: bin_window_3x3

Overview:
- Upstream stage for the 3x3 binary morphology stage (nine 1-bit taps ANDed into one pixel).
- Takes a raster-order 1-bit pixel stream (thresholded camera image) and buffers two lines in inferred block RAM.
- Emits one 9-bit neighbourhood window per image pixel, with out-of-image taps replaced by a constant border value.
- Makes erosion/dilation a single-cycle reduction downstream, with no 9-RAM replication.

Parameters:
- IMG_W, 320, pixels per line; at least 3.
- IMG_H, 240, lines per frame; at least 2.
- BORDER_VAL, 1'b1, value substituted for taps outside the image. Use 1 for erosion, 0 for dilation.

Ports:
- clk_out  in  1  pixel clock (PLL output)
- rst_n  in  1  synchronous active-low reset
- pix_valid  in  1  pixel qualifier; pixel accepted when pix_valid && in_ready
- pix_sof  in  1  marks the first pixel of a frame (valid only with pix_valid)
- pix_in  in  1  binary pixel
- in_ready  out  1  block can accept a pixel; low only in FLUSH
- win_valid  out  1  one-cycle pulse, window valid
- win  out  9  neighbourhood; bit 3*(dy+1)+(dx+1) holds pixel (x+dx, y+dy); bit4 is the centre
- win_eof  out  1  with win_valid, marks the last window of the frame (centre W-1, H-1)

Behaviour:
- Reset, synchronous on rst_n=0:
  - state IDLE; counters cleared.
  - win_valid=0, win=0, win_eof=0, in_ready=1.
  - Line-RAM contents are don't-care.
- Storage:
  - Two IMG_W x 1 line buffers, each one read and one write per accepted pixel.
  - A 3x3 tap shift register.
  - Column counter, $clog2(IMG_W) bits, wraps at IMG_W-1.
  - Line counter, $clog2(IMG_H) bits.
  - Accepted-pixel index n.
- States:
  - IDLE: in_ready=1. A pixel with pix_sof=1 is accepted as n=0, then go to PRIME. Pixels without sof are dropped.
  - PRIME: accept pixels n=1..IMG_W. The acceptance of n=IMG_W+1 moves to RUN and produces the first window.
  - RUN: each accepted pixel n produces the window centred at linear index c=n-IMG_W-1. The acceptance of n=IMG_W*IMG_H-1 goes to FLUSH.
  - FLUSH: in_ready=0 for exactly IMG_W+1 cycles. Each cycle pushes a BORDER_VAL dummy pixel and emits one window; c continues up to IMG_W*IMG_H-1. After the last window, return to IDLE.
- Latency and count:
  - win_valid is registered: high the cycle after the enabling acceptance or flush cycle.
  - Exactly IMG_W*IMG_H windows per frame, in raster order of the centre.
  - No backpressure on the output.
- Border masking uses the centre (cx, cy):
  - dx=-1 taps forced when cx=0.
  - dx=+1 taps forced when cx=IMG_W-1.
  - dy=-1 taps forced when cy=0.
  - dy=+1 taps forced when cy=IMG_H-1.
  - Masking applies to all forced taps, including those mixed from the previous line or next line across the wrap.
- pix_sof accepted in PRIME or RUN:
  - Abort the current frame; no win_eof is emitted.
  - The sof pixel becomes n=0 of a new frame and the state goes to PRIME.
  - A window already registered in the same cycle still emits; nothing further from the old frame.
- pix_valid=0 in PRIME/RUN: no state change, no window, taps held.
- rst_n low mid-frame or mid-FLUSH: outputs return to reset values on the next edge; the partial frame is discarded.

Optional Feature:
- Macro: WIN_COORD_EN.
- When defined:
  - Adds output ports win_x [$clog2(IMG_W)-1:0] and win_y [$clog2(IMG_H)-1:0], holding the centre coordinates.
  - Both are registered alongside win, valid with win_valid, and reset to 0.
- When undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=3, BORDER_VAL=1, 12 pixels all 1, sof on the first, pix_valid continuous:
  - first win_valid the cycle after the 6th accepted pixel.
  - 12 windows, all 9'h1FF.
  - in_ready low for 5 cycles after the 12th pixel.
  - win_eof only on the 12th window.
- Same stimulus with BORDER_VAL=0: window 0 = 9'h1B0; window 5 (centre 1,1) = 9'h1FF; window 11 = 9'h01B.
- Single 1 at (2,1), all else 0, BORDER_VAL=0:
  - window centre (1,1) = 9'h020 (bit5).
  - window centre (2,1) = 9'h010.
  - window centre (3,2) = 9'h001.
  - every other window has no bit of that pixel except the expected neighbours.
- pix_valid toggling 1/0 every cycle: the same 12 windows in the same order; no window emitted on idle cycles.
- pix_sof reasserted at pixel 8: no win_eof for the aborted frame; the new frame yields a full 12 windows with correct values.
- rst_n low for 1 cycle during FLUSH: next cycle win_valid=0, in_ready=1, state IDLE; a following sof frame is processed normally.

Source files
------------

// File: rtl/bin_window_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bin_window_3x3                                             |
// | Description : Two-line buffered 3x3 binary neighbourhood generator with  |
// |               constant border substitution. Optional macro WIN_COORD_EN  |
// |               adds centre-coordinate outputs win_x / win_y.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bin_window_3x3 #(
    parameter int   IMG_W      = 320,
    parameter int   IMG_H      = 240,
    parameter logic BORDER_VAL = 1'b1
) (
    input  logic                      clk_out,
    input  logic                      rst_n,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    input  logic                      pix_in,
    output logic                      in_ready,
    output logic                      win_valid,
    output logic [8:0]                win,
    output logic                      win_eof
`ifdef WIN_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0]  win_x,
    output logic [$clog2(IMG_H)-1:0]  win_y
`endif
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam int c_N_W   = $clog2(IMG_W * IMG_H + IMG_W + 1);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_N_W-1:0]   c_N_FIRST  = c_N_W'(IMG_W + 1);
    localparam logic [c_N_W-1:0]   c_N_LAST   = c_N_W'(IMG_W * IMG_H - 1);
    localparam logic [c_N_W-1:0]   c_N_FL_END = c_N_W'(IMG_W * IMG_H + IMG_W);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_N_W-1:0]   r_n, w_n_nxt;
    logic [c_COL_W-1:0] r_col, w_col_nxt, w_wr_col;
    logic [c_COL_W-1:0] r_cx;
    logic [c_ROW_W-1:0] r_cy;
    logic               w_push, w_fire, w_new_frame, w_pix;

    logic               r_lb0 [IMG_W];
    logic               r_lb1 [IMG_W];
    logic               r_lb0_q, r_lb1_q;

    logic [2:0]         r_top, r_mid, r_bot;
    logic [2:0]         w_top_nxt, w_mid_nxt, w_bot_nxt;
    logic [8:0]         w_force, w_win_nxt;
    logic               w_last;

    logic               r_win_valid, r_win_eof;
    logic [8:0]         r_win;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_fire      = 1'b0;
        w_new_frame = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (pix_valid && pix_sof) begin
                    w_push      = 1'b1;
                    w_new_frame = 1'b1;
                    w_state_nxt = c_ST_PRIME;
                end
            end
            c_ST_PRIME, c_ST_RUN: begin
                if (pix_valid) begin
                    w_push = 1'b1;
                    if (pix_sof) begin
                        w_new_frame = 1'b1;
                        w_state_nxt = c_ST_PRIME;
                    end else if (r_state == c_ST_PRIME) begin
                        if (r_n == c_N_FIRST) begin
                            w_fire      = 1'b1;
                            w_state_nxt = c_ST_RUN;
                        end
                    end else begin
                        w_fire = 1'b1;
                        if (r_n == c_N_LAST) begin
                            w_state_nxt = c_ST_FLUSH;
                        end
                    end
                end
            end
            c_ST_FLUSH: begin
                w_push = 1'b1;
                w_fire = 1'b1;
                if (r_n == c_N_FL_END) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // The sof pixel is always column 0, whatever column the aborted frame reached.
    always_comb begin
        w_pix    = (r_state == c_ST_FLUSH) ? BORDER_VAL : pix_in;
        w_wr_col = w_new_frame ? '0 : r_col;
        w_n_nxt  = r_n;
        if (w_new_frame) begin
            w_n_nxt = c_N_W'(1);
        end else if (w_push) begin
            w_n_nxt = (w_state_nxt == c_ST_IDLE) ? '0 : r_n + c_N_W'(1);
        end
        w_col_nxt = r_col;
        if (!rst_n) begin
            w_col_nxt = '0;
        end else if (w_push) begin
            w_col_nxt = (w_wr_col == c_COL_LAST) ? '0 : w_wr_col + c_COL_W'(1);
        end
    end

    // Read address is the next pixel's column, so read data is ready when it arrives.
    always_ff @(posedge clk_out) begin
        if (rst_n && w_push) begin
            r_lb0[w_wr_col] <= w_pix;
            r_lb1[w_wr_col] <= r_lb0_q;
        end
        r_lb0_q <= r_lb0[w_col_nxt];
        r_lb1_q <= r_lb1[w_col_nxt];
    end

    always_comb begin
        w_top_nxt = {r_lb1_q, r_top[2:1]};
        w_mid_nxt = {r_lb0_q, r_mid[2:1]};
        w_bot_nxt = {w_pix,   r_bot[2:1]};
        w_force   = (9'b001_001_001 & {9{r_cx == '0}})
                  | (9'b100_100_100 & {9{r_cx == c_COL_LAST}})
                  | (9'b000_000_111 & {9{r_cy == '0}})
                  | (9'b111_000_000 & {9{r_cy == c_ROW_LAST}});
        w_win_nxt = ({w_bot_nxt, w_mid_nxt, w_top_nxt} & ~w_force)
                  | (w_force & {9{BORDER_VAL}});
        w_last    = (r_cx == c_COL_LAST) && (r_cy == c_ROW_LAST);
    end

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_n         <= '0;
            r_col       <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_top       <= '0;
            r_mid       <= '0;
            r_bot       <= '0;
            r_win_valid <= 1'b0;
            r_win       <= '0;
            r_win_eof   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_col       <= w_col_nxt;
            r_win_valid <= w_fire;
            r_win_eof   <= w_fire && w_last;
            if (w_push) begin
                r_top <= w_top_nxt;
                r_mid <= w_mid_nxt;
                r_bot <= w_bot_nxt;
            end
            if (w_fire) begin
                r_win <= w_win_nxt;
            end
            if (w_new_frame) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (w_fire) begin
                if (r_cx == c_COL_LAST) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == c_ROW_LAST) ? '0 : r_cy + c_ROW_W'(1);
                end else begin
                    r_cx <= r_cx + c_COL_W'(1);
                end
            end
        end
    end

`ifdef WIN_COORD_EN
    logic [c_COL_W-1:0] r_win_x;
    logic [c_ROW_W-1:0] r_win_y;

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            r_win_x <= '0;
            r_win_y <= '0;
        end else if (w_fire) begin
            r_win_x <= r_cx;
            r_win_y <= r_cy;
        end
    end

    assign win_x = r_win_x;
    assign win_y = r_win_y;
`endif

    assign in_ready  = (r_state != c_ST_FLUSH);
    assign win_valid = r_win_valid;
    assign win       = r_win;
    assign win_eof   = r_win_eof;

endmodule
`default_nettype wire

// File: tb/tb_bin_window_3x3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bin_window_3x3                                          |
// | Description : Self-checking bench for bin_window_3x3 (4x3 image, border  |
// |               values 1 and 0 side by side).                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bin_window_3x3;

    localparam int W = 4;
    localparam int H = 3;
    localparam int NPIX = W * H;

    typedef struct {
        logic [8:0] w;
        logic       eof;
        int         x;
        int         y;
    } exp_t;

    typedef struct {
        logic [11:0] img;
        int          idx;
        logic [8:0]  e0;
        logic [8:0]  e1;
    } vec_t;

    logic clk_out = 1'b0;
    logic rst_n, pix_valid, pix_sof, pix_in;
    logic in_ready1, win_valid1, win_eof1, in_ready0, win_valid0, win_eof0;
    logic [8:0] win1, win0;
    logic [1:0] x1, y1, x0, y0;

    int n_vec  = 0;
    int n_miss = 0;
    exp_t q1[$], q0[$];
    logic [8:0] cap1[$], cap0[$];
    exp_t e1, e0;
    bit have1, have0;
    vec_t tbl[8];

    always #5 clk_out = ~clk_out;

    bin_window_3x3 #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b1)) u_dut1 (
        .clk_out(clk_out), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_in(pix_in), .in_ready(in_ready1), .win_valid(win_valid1), .win(win1),
        .win_eof(win_eof1)
`ifdef WIN_COORD_EN
        , .win_x(x1), .win_y(y1)
`endif
    );

    bin_window_3x3 #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b0)) u_dut0 (
        .clk_out(clk_out), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_in(pix_in), .in_ready(in_ready0), .win_valid(win_valid0), .win(win0),
        .win_eof(win_eof0)
`ifdef WIN_COORD_EN
        , .win_x(x0), .win_y(y0)
`endif
    );

`ifndef WIN_COORD_EN
    assign x1 = '0;
    assign y1 = '0;
    assign x0 = '0;
    assign y0 = '0;
`endif

    // Reference window: taps read straight from the image, border where outside it.
    function automatic logic [8:0] ref_win(input logic [11:0] img, input int x, input int y,
                                           input logic bv);
        logic [8:0] r;
        r = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int xx;
                int yy;
                xx = x + dx;
                yy = y + dy;
                if (xx < 0 || xx >= W || yy < 0 || yy >= H)
                    r[3*(dy+1)+(dx+1)] = bv;
                else
                    r[3*(dy+1)+(dx+1)] = img[yy*W+xx];
            end
        end
        return r;
    endfunction

    task automatic expect_range(input logic [11:0] img, input int c_hi, input bit full);
        exp_t e;
        for (int c = 0; c <= c_hi; c++) begin
            e.x   = c % W;
            e.y   = c / W;
            e.eof = full && (c == NPIX - 1);
            e.w   = ref_win(img, e.x, e.y, 1'b1);
            q1.push_back(e);
            e.w   = ref_win(img, e.x, e.y, 1'b0);
            q0.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic score(input string tag, input logic [8:0] gw, input logic geof,
                         input logic [1:0] gx, input logic [1:0] gy, input bit have,
                         input exp_t e);
        n_vec++;
        if (!have) begin
            n_miss++;
            $display("FAIL %s unexpected window: got win=%03h eof=%b, required none", tag, gw, geof);
        end else if (gw !== e.w || geof !== e.eof) begin
            n_miss++;
            $display("FAIL %s window (%0d,%0d): got win=%03h eof=%b required win=%03h eof=%b",
                     tag, e.x, e.y, gw, geof, e.w, e.eof);
        end
`ifdef WIN_COORD_EN
        else if (int'(gx) != e.x || int'(gy) != e.y) begin
            n_miss++;
            $display("FAIL %s coord: got (%0d,%0d) required (%0d,%0d)", tag, gx, gy, e.x, e.y);
        end
`endif
    endtask

    always @(negedge clk_out) begin
        if (win_valid1) begin
            have1 = (q1.size() != 0);
            if (have1) e1 = q1.pop_front();
            cap1.push_back(win1);
            score("b1", win1, win_eof1, x1, y1, have1, e1);
        end
        if (win_valid0) begin
            have0 = (q0.size() != 0);
            if (have0) e0 = q0.pop_front();
            cap0.push_back(win0);
            score("b0", win0, win_eof0, x0, y0, have0, e0);
        end
    end

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic send_pix(input logic sof, input logic p);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_in    = p;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = 1'b0;
    endtask

    // mode 0: back-to-back, 1: idle cycle after every pixel, 2: random idles
    task automatic send_frame(input logic [11:0] img, input int npix, input int mode,
                              input bit chk_first);
        for (int i = 0; i < npix; i++) begin
            send_pix(i == 0, img[i]);
            if (chk_first && i == W)     chk("no_win_before_6th", int'(win_valid1), 0);
            if (chk_first && i == W + 1) chk("first_win_after_6th", int'(win_valid1), 1);
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) tick();
        end
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        while (!in_ready1 && low < 40) begin
            tick();
            low++;
        end
        if (low >= 40) begin
            n_vec++;
            n_miss++;
            $display("FAIL flush_timeout: in_ready low for %0d cycles, required high", low);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic [11:0] img;
        int npix;

        tbl[0] = '{12'hFFF, 0,  9'h1B0, 9'h1FF};
        tbl[1] = '{12'hFFF, 5,  9'h1FF, 9'h1FF};
        tbl[2] = '{12'hFFF, 11, 9'h01B, 9'h1FF};
        tbl[3] = '{12'h040, 5,  9'h020, 9'h020};
        tbl[4] = '{12'h040, 6,  9'h010, 9'h010};
        tbl[5] = '{12'h040, 11, 9'h001, 9'h1E5};
        tbl[6] = '{12'h040, 10, 9'h002, 9'h1C2};
        tbl[7] = '{12'h000, 0,  9'h000, 9'h04F};

        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready_b1", int'(in_ready1), 1);
        chk("rst_in_ready_b0", int'(in_ready0), 1);
        chk("rst_win_valid_b1", int'(win_valid1), 0);
        chk("rst_win_valid_b0", int'(win_valid0), 0);
        chk("rst_win_b1", int'(win1), 0);
        chk("rst_win_b0", int'(win0), 0);
        chk("rst_eof_b1", int'(win_eof1), 0);
        chk("rst_eof_b0", int'(win_eof0), 0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 8; r++) begin
            cap1.delete();
            cap0.delete();
            expect_range(tbl[r].img, NPIX - 1, 1'b1);
            send_frame(tbl[r].img, NPIX, 0, r == 0);
            wait_idle(low);
            if (r == 0) chk("flush_ready_low_cycles", low, W + 1);
            chk($sformatf("tbl%0d_count", r), cap1.size(), NPIX);
            chk($sformatf("tbl%0d_b0_win%0d", r, tbl[r].idx), int'(cap0[tbl[r].idx]), int'(tbl[r].e0));
            chk($sformatf("tbl%0d_b1_win%0d", r, tbl[r].idx), int'(cap1[tbl[r].idx]), int'(tbl[r].e1));
        end

        // Valid toggling every other cycle
        cap1.delete();
        expect_range(12'hA5C, NPIX - 1, 1'b1);
        send_frame(12'hA5C, NPIX, 1, 1'b0);
        wait_idle(low);
        chk("toggle_count", cap1.size(), NPIX);

        // sof re-asserted at pixel 8 aborts the first frame
        expect_range(12'h3C6, 8 - W - 2, 1'b0);
        send_frame(12'h3C6, 8, 0, 1'b0);
        expect_range(12'h9B1, NPIX - 1, 1'b1);
        send_frame(12'h9B1, NPIX, 0, 1'b0);
        wait_idle(low);

        // Reset one cycle into FLUSH: windows up to centre 7 only
        expect_range(12'h7E3, 7, 1'b0);
        send_frame(12'h7E3, NPIX, 0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("flushrst_win_valid", int'(win_valid1), 0);
        chk("flushrst_in_ready", int'(in_ready1), 1);
        chk("flushrst_eof", int'(win_eof1), 0);
        chk("flushrst_win", int'(win0), 0);
        rst_n = 1'b1;
        chk("flushrst_pending_b1", q1.size(), 0);
        chk("flushrst_pending_b0", q0.size(), 0);

        // Non-sof pixel in IDLE is dropped, then a normal frame
        send_pix(1'b0, 1'b1);
        tick();
        expect_range(12'h5A7, NPIX - 1, 1'b1);
        send_frame(12'h5A7, NPIX, 0, 1'b0);
        wait_idle(low);

        // Randomized frames with random gaps and random aborts
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                img  = 12'($urandom);
                npix = $urandom_range(W + 3, NPIX - 1);
                expect_range(img, npix - W - 2, 1'b0);
                send_frame(img, npix, $urandom_range(0, 2), 1'b0);
            end
            img = 12'($urandom);
            expect_range(img, NPIX - 1, 1'b1);
            send_frame(img, NPIX, $urandom_range(0, 2), 1'b0);
            wait_idle(low);
        end

        repeat (3) tick();
        chk("final_pending_b1", q1.size(), 0);
        chk("final_pending_b0", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
